sseg_scan_mux: RTL and testbench

//  Parametrised multi-digit 7-segment scan driver with active-low anodes and segments.

---
 rtl/sseg_scan_mux.sv | 159 +++++++++++++++
 tb/tb_sseg_scan_mux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: multi-digit 7-segment scan driver, double-buffered glyphs,
// brightness PWM, anti-ghost guard, per-digit blink. Active-low an_out/sseg_out.
// Ports: clk, reset (sync, high), load, codes[5*NDIG], dp_in/en_in/blink_in[NDIG],
//        brightness[4] -> an_out[NDIG], sseg_out[8] {dp,a..g}, frame_start.
module sseg_scan_mux #(
  parameter int NDIG      = 4,
  parameter int SLOT_W    = 16,
  parameter int GUARD     = 64,
  parameter int BLINK_DIV = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [5*NDIG-1:0]    codes,
  input  logic [NDIG-1:0]      dp_in,
  input  logic [NDIG-1:0]      en_in,
  input  logic [NDIG-1:0]      blink_in,
  input  logic [3:0]           brightness,
  output logic [NDIG-1:0]      an_out,
  output logic [7:0]           sseg_out,
  output logic                 frame_start
);

  localparam int DW = $clog2(NDIG);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0]     DLAST  = DW'(NDIG - 1);
  localparam logic [BW-1:0]     BLAST  = BW'(BLINK_DIV - 1);
  localparam logic [SLOT_W-1:0] GSTART = SLOT_W'(GUARD);

  logic [SLOT_W-1:0] s;
  logic [DW-1:0]     d;

  logic [4:0]        pend_code [NDIG];
  logic [4:0]        act_code  [NDIG];
  logic [NDIG-1:0]   pend_dp, pend_en, pend_blink;
  logic [NDIG-1:0]   act_dp, act_en, act_blink;
  logic              pend_valid;
  logic              phase;
  logic [BW-1:0]     bcnt;
  logic [3:0]        bright_l;

  logic              fs, commit, blink_wrap, cur_phase, lit;
  logic [3:0]        cur_bright;
  logic [NDIG-1:0]   cur_dp, cur_en, cur_blink;
  logic [4:0]        cur_code;
  logic [NDIG-1:0]   an_nxt;
  logic [7:0]        sseg_nxt;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    logic [6:0] g;
    case (c)
      5'h00: g = 7'h01;
      5'h01: g = 7'h4F;
      5'h02: g = 7'h12;
      5'h03: g = 7'h06;
      5'h04: g = 7'h4C;
      5'h05: g = 7'h24;
      5'h06: g = 7'h20;
      5'h07: g = 7'h0F;
      5'h08: g = 7'h00;
      5'h09: g = 7'h04;
      5'h0A: g = 7'h08;
      5'h0B: g = 7'h60;
      5'h0C: g = 7'h31;
      5'h0D: g = 7'h42;
      5'h0E: g = 7'h30;
      5'h0F: g = 7'h38;
      5'h10: g = 7'h41;
      5'h11: g = 7'h7E;
      5'h12: g = 7'h7F;
      5'h13: g = 7'h09;
      5'h14: g = 7'h62;
      5'h15: g = 7'h1C;
      5'h16: g = 7'h79;
      5'h17: g = 7'h49;
      default: g = 7'h7E;
    endcase
    return g;
  endfunction

  // On the frame-start cycle the values about to be committed are used,
  // so the first slot of a frame already shows the new frame's settings.
  always_comb begin
    fs         = (s == '0) && (d == '0);
    commit     = fs && pend_valid;
    blink_wrap = fs && (bcnt == BLAST);
    cur_phase  = blink_wrap ? ~phase : phase;
    cur_bright = fs ? brightness : bright_l;
    cur_dp     = commit ? pend_dp    : act_dp;
    cur_en     = commit ? pend_en    : act_en;
    cur_blink  = commit ? pend_blink : act_blink;
    cur_code   = commit ? pend_code[d] : act_code[d];
    lit        = cur_en[d]
               && !(cur_blink[d] && cur_phase)
               && (s >= GSTART)
               && (s[SLOT_W-1 -: 4] <= cur_bright);
    an_nxt     = '1;
    sseg_nxt   = 8'hFF;
    if (lit) begin
      an_nxt   = ~(NDIG'(1) << d);
      sseg_nxt = {~cur_dp[d], glyph(cur_code)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s           <= '0;
      d           <= '0;
      for (int i = 0; i < NDIG; i++) begin
        pend_code[i] <= '0;
        act_code[i]  <= '0;
      end
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_blink  <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_blink   <= '0;
      pend_valid  <= 1'b0;
      phase       <= 1'b0;
      bcnt        <= '0;
      bright_l    <= 4'hF;
      an_out      <= '1;
      sseg_out    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      s           <= s + SLOT_W'(1);
      if (s == '1)
        d <= (d == DLAST) ? '0 : d + DW'(1);
      an_out      <= an_nxt;
      sseg_out    <= sseg_nxt;
      frame_start <= fs;
      if (fs) begin
        bright_l <= brightness;
        bcnt     <= blink_wrap ? '0 : bcnt + BW'(1);
        if (blink_wrap)
          phase <= ~phase;
      end
      if (commit) begin
        for (int i = 0; i < NDIG; i++)
          act_code[i] <= pend_code[i];
        act_dp     <= pend_dp;
        act_en     <= pend_en;
        act_blink  <= pend_blink;
        pend_valid <= 1'b0;
      end
      // A load on the commit cycle lands in pending after the copy.
      if (load) begin
        for (int i = 0; i < NDIG; i++)
          pend_code[i] <= codes[5*i +: 5];
        pend_dp    <= dp_in;
        pend_en    <= en_in;
        pend_blink <= blink_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: directed bench for sseg_scan_mux (3 digits, 64-clk slots)
// with a cycle-count reference model and hand-computed spot checks.
module tb_sseg_scan_mux;

  localparam int NDIG = 3;
  localparam int SLOT_W = 6;
  localparam int GUARD = 2;
  localparam int BLINK_DIV = 2;
  localparam int SLOT = 64;
  localparam int FRAME = 192;

  localparam logic [6:0] GT [32] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38,
    7'h41, 7'h7E, 7'h7F, 7'h09, 7'h62, 7'h1C, 7'h79, 7'h49,
    7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [14:0] codes = '0;
  logic [2:0]  dp_in = '0;
  logic [2:0]  en_in = '0;
  logic [2:0]  blink_in = '0;
  logic [3:0]  brightness = 4'd15;
  logic [2:0]  an_out;
  logic [7:0]  sseg_out;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  int cur = 0;

  sseg_scan_mux #(
    .NDIG(NDIG), .SLOT_W(SLOT_W),
    .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .load(load),
    .codes(codes), .dp_in(dp_in), .en_in(en_in),
    .blink_in(blink_in), .brightness(brightness),
    .an_out(an_out), .sseg_out(sseg_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: position is derived from cycles since reset.
  int         k;
  int         nfs;
  int         m_bright;
  logic [4:0] mp_code [NDIG];
  logic [4:0] ma_code [NDIG];
  logic [2:0] mp_dp, mp_en, mp_bl;
  logic [2:0] ma_dp, ma_en, ma_bl;
  bit         mp_v;
  logic [2:0] exp_an;
  logic [7:0] exp_sseg;
  logic       exp_fs;

  always @(posedge clk) begin : model
    int sm;
    int dm;
    bit ph;
    bit lit;
    if (reset) begin
      k = 0;
      nfs = 0;
      m_bright = 15;
      for (int i = 0; i < NDIG; i++) begin
        mp_code[i] = '0;
        ma_code[i] = '0;
      end
      mp_dp = '0; mp_en = '0; mp_bl = '0;
      ma_dp = '0; ma_en = '0; ma_bl = '0;
      mp_v = 0;
      exp_an = 3'b111;
      exp_sseg = 8'hFF;
      exp_fs = 1'b0;
    end else begin
      sm = k % SLOT;
      dm = (k / SLOT) % NDIG;
      exp_fs = (k % FRAME) == 0;
      if (exp_fs) begin
        nfs++;
        m_bright = int'(brightness);
        if (mp_v) begin
          for (int i = 0; i < NDIG; i++)
            ma_code[i] = mp_code[i];
          ma_dp = mp_dp; ma_en = mp_en; ma_bl = mp_bl;
          mp_v = 0;
        end
      end
      ph = ((nfs / BLINK_DIV) % 2) == 1;
      lit = ma_en[dm] && !(ma_bl[dm] && ph)
            && (sm >= GUARD)
            && ((sm >> (SLOT_W - 4)) <= m_bright);
      exp_an = lit ? ~(3'b001 << dm) : 3'b111;
      exp_sseg = lit ? {~ma_dp[dm], GT[ma_code[dm]]} : 8'hFF;
      if (load) begin
        for (int i = 0; i < NDIG; i++)
          mp_code[i] = codes[5*i +: 5];
        mp_dp = dp_in; mp_en = en_in; mp_bl = blink_in;
        mp_v = 1;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if (an_out !== exp_an || sseg_out !== exp_sseg
          || frame_start !== exp_fs) begin
        n_bad++;
        $display("FAIL model t=%0t an=%b want %b sseg=%h want %h fs=%b want %b",
                 $time, an_out, exp_an, sseg_out, exp_sseg,
                 frame_start, exp_fs);
      end
      n_cmp++;
      if ($countones(~an_out) > 1) begin
        n_bad++;
        $display("FAIL onehot t=%0t an=%b want at most one low",
                 $time, an_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [11:0] got,
                     input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk_out(input string nm, input logic [2:0] an_w,
                         input logic [7:0] ss_w);
    chk(nm, {1'b0, an_out, sseg_out}, {1'b0, an_w, ss_w});
  endtask

  task automatic wait_fs(input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge clk);
      hit = frame_start;
    end
    cur = 0;
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s frame_start timeout got=0 want=1", nm);
    end
  endtask

  task automatic to_pos(input int p);
    while (cur < p) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic pulse_load(input logic [14:0] c, input logic [2:0] dp,
                            input logic [2:0] en, input logic [2:0] bl);
    codes = c; dp_in = dp; en_in = en; blink_in = bl;
    load = 1'b1;
    @(negedge clk);
    cur++;
    load = 1'b0;
  endtask

  initial begin
    bit b0 [8];
    bit b1 [8];
    int per;
    int c0;
    int c1;
    bit pat_ok;
    bit rep_ok;
    logic [3:0] pat;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk_out("reset_out", 3'b111, 8'hFF);
    chk("reset_fs", {11'b0, frame_start}, 12'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_fs", {11'b0, frame_start}, 12'd1);
    repeat (1000) @(negedge clk);
    chk_out("idle_blank", 3'b111, 8'hFF);
    wait_fs("t1a");
    per = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      per++;
      if (frame_start) break;
    end
    cur = 0;
    chk("fs_period", 12'(per), 12'd192);

    // 2: first load, committed at next frame
    to_pos(5);
    pulse_load({5'h0A, 5'h01, 5'h00}, 3'b010, 3'b111, 3'b000);
    to_pos(100);
    chk_out("precommit_dark", 3'b111, 8'hFF);
    wait_fs("t2");
    to_pos(1);   chk_out("d0_guard", 3'b111, 8'hFF);
    to_pos(2);   chk_out("d0_s2", 3'b110, 8'h81);
    to_pos(63);  chk_out("d0_s63", 3'b110, 8'h81);
    to_pos(66);  chk_out("d1_s2", 3'b101, 8'h4F);
    to_pos(191); chk_out("d2_s63", 3'b011, 8'h88);

    // 3: mid-frame load only shows from the next frame
    wait_fs("t3a");
    to_pos(74);
    pulse_load({5'h05, 5'h10, 5'h13}, 3'b000, 3'b111, 3'b000);
    to_pos(130); chk_out("old_kept", 3'b011, 8'h88);
    wait_fs("t3b");
    to_pos(2);   chk_out("new_d0", 3'b110, 8'h89);
    to_pos(66);  chk_out("new_d1", 3'b101, 8'hC1);
    to_pos(130); chk_out("new_d2", 3'b011, 8'hA4);

    // 4: brightness 0 then 7
    brightness = 4'd0;
    wait_fs("t4a");
    to_pos(3);   chk_out("b0_s3", 3'b110, 8'h89);
    to_pos(4);   chk_out("b0_s4", 3'b111, 8'hFF);
    to_pos(67);  chk_out("b0_d1s3", 3'b101, 8'hC1);
    to_pos(68);  chk_out("b0_d1s4", 3'b111, 8'hFF);
    brightness = 4'd7;
    wait_fs("t4b");
    to_pos(95);  chk_out("b7_s31", 3'b101, 8'hC1);
    to_pos(96);  chk_out("b7_s32", 3'b111, 8'hFF);
    to_pos(130); chk_out("b7_d2", 3'b011, 8'hA4);
    brightness = 4'd15;

    // 5: blink on digit 0 only
    to_pos(140);
    pulse_load({5'h05, 5'h10, 5'h13}, 3'b000, 3'b111, 3'b001);
    wait_fs("t5a");
    for (int f = 0; f < 8; f++) begin
      to_pos(10);
      b0[f] = (an_out == 3'b110);
      to_pos(74);
      b1[f] = (an_out == 3'b101);
      wait_fs("t5b");
    end
    c0 = 0;
    c1 = 0;
    for (int f = 0; f < 8; f++) begin
      c0 += int'(b0[f]);
      c1 += int'(b1[f]);
    end
    pat = {b0[3], b0[2], b0[1], b0[0]};
    pat_ok = (pat == 4'b0011) || (pat == 4'b0110)
          || (pat == 4'b1100) || (pat == 4'b1001);
    rep_ok = 1;
    for (int f = 0; f < 4; f++)
      if (b0[f] != b0[f+4]) rep_ok = 0;
    chk("blink_d0_pat", {11'b0, pat_ok}, 12'd1);
    chk("blink_d0_rep", {11'b0, rep_ok}, 12'd1);
    chk("blink_d0_cnt", 12'(c0), 12'd4);
    chk("blink_d1_cnt", 12'(c1), 12'd8);

    // 6: out-of-table code, then reset mid-slot
    to_pos(5);
    pulse_load({5'h05, 5'h10, 5'h1C}, 3'b000, 3'b001, 3'b000);
    wait_fs("t6a");
    to_pos(5);   chk_out("code1c", 3'b110, 8'hFE);
    to_pos(20);
    reset = 1'b1;
    @(negedge clk);
    chk_out("rst_mid", 3'b111, 8'hFF);
    chk("rst_fs", {11'b0, frame_start}, 12'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_fs_after", {11'b0, frame_start}, 12'd1);
    cur = 0;
    to_pos(10);  chk_out("cleared_f0", 3'b111, 8'hFF);
    wait_fs("t6b");
    to_pos(10);  chk_out("cleared_f1", 3'b111, 8'hFF);
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
